// File: rtl/adder_seq_ctrl_if.sv
// Handshake and operand/result bundle for the multi-precision add/subtract
// sequencer. The master side issues requests; the slave side (the
// sequencer) returns busy/done and the registered result.
interface adder_seq_ctrl_if #(
    parameter int WORDS = 4
);
    localparam int W = WORDS * 6;

    logic         start;
    logic         sub;
    logic         carry_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    modport master (
        output start, sub, carry_in, a, b,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, sub, carry_in, a, b,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer. One shared 6-bit ripple-carry
// adder processes a WORDS*6-bit operation one slice per cycle, LSB first,
// with the inter-slice carry held in a register.

// 6-bit ripple-carry adder slice.
module adder_6bit (
    input  logic [5:0] i_a,
    input  logic [5:0] i_b,
    input  logic       i_ci,
    output logic [5:0] o_s,
    output logic       o_co
);
    logic [6:0] w_c;

    // Ripple the carry through six full-adder cells.
    always_comb begin
        w_c    = 7'd0;
        o_s    = 6'd0;
        w_c[0] = i_ci;
        for (int i = 0; i < 6; i++) begin
            o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_co = w_c[6];
    end
endmodule

module adder_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    adder_seq_ctrl_if.slave   bus
);
    localparam int W  = WORDS * 6;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_opa;
    logic [W-1:0]  r_opb;
    logic [W-1:0]  r_sum;
    logic          r_carry_out;
    logic          r_overflow;
    logic          r_busy;
    logic          r_done;

    logic [5:0]    w_slice_a;
    logic [5:0]    w_slice_b;
    logic [5:0]    w_add_sum;
    logic          w_add_co;

    // opB already holds ~b for subtraction, so the adder only ever adds.
    assign w_slice_a = r_opa[r_idx*6 +: 6];
    assign w_slice_b = r_opb[r_idx*6 +: 6];

    adder_6bit u_adder (
        .i_a  (w_slice_a),
        .i_b  (w_slice_b),
        .i_ci (r_carry),
        .o_s  (w_add_sum),
        .o_co (w_add_co)
    );

    // Sequencer FSM: accept in IDLE, one slice per RUN cycle, one-cycle DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= {IW{1'b0}};
            r_carry     <= 1'b0;
            r_opa       <= {W{1'b0}};
            r_opb       <= {W{1'b0}};
            r_sum       <= {W{1'b0}};
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_opa   <= bus.a;
                        r_opb   <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub ? 1'b1 : bus.carry_in;
                        r_idx   <= {IW{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*6 +: 6] <= w_add_sum;
                    r_carry             <= w_add_co;
                    if (r_idx == LAST_IDX) begin
                        // Final slice: its sum msb is the result sign bit.
                        r_carry_out <= w_add_co;
                        r_overflow  <= (r_opa[W-1] == r_opb[W-1]) &&
                                       (w_add_sum[5] != r_opa[W-1]);
                        r_idx       <= {IW{1'b0}};
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx       <= r_idx + IW'(1);
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-precision add/subtract sequencer. Reuses one instance of the team's 6-bit ripple-carry adder (adder_6bit), one 6-bit slice per cycle, LSB slice first.
- Carry chains between slices through an internal carry register.
- Start/busy/done handshake; operands latched at start. Computes WORDS*6-bit results without a wide adder.

Parameters:
- WORDS, 4, number of 6-bit slices. Operand width W = WORDS*6. Legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- sub  input  1  1 = compute a - b; 0 = compute a + b + carry_in
- carry_in  input  1  initial carry; ignored when sub=1
- a  input  W  operand A; latched at accepted start
- b  input  W  operand B; latched at accepted start
- busy  output  1  high while slices are being processed (RUN)
- done  output  1  single-cycle pulse; result valid
- sum  output  W  result; held from done until next accepted start
- carry_out  output  1  carry out of MSB slice (sub: 1 = no borrow)
- overflow  output  1  two's-complement overflow of the W-bit operation

Behaviour:
- Reset (async, rst=1): state=IDLE, slice index=0, carry reg=0, operand regs=0, sum=0, carry_out=0, overflow=0, busy=0, done=0. Takes effect immediately, including mid-RUN; the in-flight operation is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at rising edge: latch a into opA; latch b into opB, or ~b when sub=1.
  - carry reg <= sub ? 1 : carry_in; idx <= 0; go to RUN.
  - start=0: remain IDLE.
- RUN (busy=1):
  - Each cycle the adder sees opA[idx*6+:6], opB[idx*6+:6] and the carry reg.
  - At the edge, the adder sum is written to sum[idx*6+:6], the carry reg takes the adder carry, and idx increments.
  - On the edge with idx==WORDS-1: carry_out <= adder carry; overflow <= (opA msb == opB msb) && (adder sum msb != opA msb); go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; next state IDLE unconditionally.
- sum slices still to be processed hold stale/partial data during RUN. sum, carry_out and overflow are valid from the done cycle and held until the next accepted start.
- start is ignored in RUN and DONE; there is no queuing. Operand changes after acceptance are ignored.
- Latency: start sampled at edge 0 -> RUN during cycles 1..WORDS -> done high in cycle WORDS+1. With start held high, a new operation begins every WORDS+2 cycles.
- WORDS=1: single RUN cycle; the same rules apply.
- Arithmetic: sum = (A + B_eff + c0) mod 2^W, where B_eff = ~b when sub=1 and c0 = 1 when sub=1. carry_out is bit W of the unbounded sum.
- busy and done are never high together. done is never high in two consecutive cycles.

Test Plan (WORDS=4, W=24):
- Inter-slice carry: a=0x00003F, b=0x000001, sub=0, carry_in=0, start pulse -> busy high 4 cycles, done in cycle 5 after start edge; sum=0x000040, carry_out=0, overflow=0.
- Full ripple: a=0xFFFFFF, b=0x000001, carry_in=0 -> sum=0x000000, carry_out=1, overflow=0. Same operands with carry_in=1 -> sum=0x000001, carry_out=1.
- Subtract with borrow: a=0x000005, b=0x000007, sub=1, carry_in=0 -> sum=0xFFFFFE, carry_out=0, overflow=0. Separately, a=0x000007, b=0x000005, sub=1 -> sum=0x000002, carry_out=1.
- Signed overflow: a=0x7FFFFF, b=0x000001, sub=0 -> sum=0x800000, overflow=1, carry_out=0. Separately, a=0x800000, b=0x000001, sub=1 -> sum=0x7FFFFF, overflow=1.
- Handshake: start again during RUN with a=b=0x111111 -> ignored; the first result is intact and a single done pulse occurs. With start held high for 20 cycles -> done pulses exactly every 6 cycles, and operands are latched only in IDLE.
- Reset mid-operation: assert rst during the 2nd RUN cycle -> busy, done, sum, carry_out and overflow all go 0 immediately, and no done follows. After rst release, start with a=0x000010, b=0x000020 -> sum=0x000030, done after 5 cycles.
